// File: rtl/capture_pkg.sv
// Shared types and default widths for the logic capture trigger path.
package capture_pkg;

    localparam int CAPTURE_SAMPLE_W = 16;
    localparam int CAPTURE_CNT_W    = 16;

    typedef enum logic [2:0] {
        DISARMED,
        ARMED,
        FIRED,
        POST,
        DONE
    } trig_state_t;

endpackage

// File: rtl/trigger_match.sv
// Level/edge sample qualifier for the capture trigger.
// Edge matching and the prev register exist only when CAPTURE_TRIGGER_EDGE_EN is defined.
module trigger_match
    import capture_pkg::*;
#(
    parameter int SAMPLE_W = CAPTURE_SAMPLE_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                clear,
    input  logic [SAMPLE_W-1:0] cfg_mask,
    input  logic [SAMPLE_W-1:0] cfg_value,
    input  logic [SAMPLE_W-1:0] cfg_edge_mask,
    input  logic [SAMPLE_W-1:0] cfg_edge_pol,
    output logic                qualify
);

    logic level_ok;
    logic edge_ok;

    assign level_ok = ((sample ^ cfg_value) & cfg_mask) == '0;

`ifdef CAPTURE_TRIGGER_EDGE_EN
    logic [SAMPLE_W-1:0] prev;
    logic                prev_ok;
    logic [SAMPLE_W-1:0] edge_bits;

    // prev_ok stays low until one valid sample has been seen since arming
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            prev    <= '0;
            prev_ok <= 1'b0;
        end else if (sample_valid) begin
            prev    <= sample;
            prev_ok <= 1'b1;
        end
    end

    assign edge_bits = (cfg_edge_pol & ~prev & sample) | (~cfg_edge_pol & prev & ~sample);
    assign edge_ok   = (cfg_edge_mask == '0) ||
                       (prev_ok && ((edge_bits & cfg_edge_mask) == cfg_edge_mask));
`else
    logic unused_edge;
    assign unused_edge = ^{clock, reset, clear, cfg_edge_mask, cfg_edge_pol};
    assign edge_ok     = 1'b1;
`endif

    assign qualify = sample_valid && level_ok && edge_ok;

endmodule

// File: rtl/capture_trigger_unit.sv
// Trigger qualifier and post-trigger sample counter ahead of the analyzer control FSM.
// Optional edge triggering is built when CAPTURE_TRIGGER_EDGE_EN is defined.
module capture_trigger_unit
    import capture_pkg::*;
#(
    parameter int SAMPLE_W = CAPTURE_SAMPLE_W,
    parameter int CNT_W    = CAPTURE_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                idle,
    input  logic                pre_trigger,
    input  logic                post_trigger,
    input  logic [SAMPLE_W-1:0] cfg_mask,
    input  logic [SAMPLE_W-1:0] cfg_value,
    input  logic [SAMPLE_W-1:0] cfg_edge_mask,
    input  logic [SAMPLE_W-1:0] cfg_edge_pol,
    input  logic [CNT_W-1:0]    cfg_match_count,
    input  logic [CNT_W-1:0]    cfg_post_samples,
    output logic                saw_trigger,
    output logic                complete,
    output logic [CNT_W-1:0]    pre_count
);

    trig_state_t      state;
    trig_state_t      state_next;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] post_cnt;
    logic [CNT_W-1:0] pre_cnt;
    logic [CNT_W-1:0] match_target;
    logic [CNT_W:0]   match_inc;
    logic [CNT_W:0]   post_inc;
    logic             qualify;
    logic             fsm_quiet;
    logic             armed_active;
    logic             post_active;
    logic             fire;
    logic             finish;
    logic             saw_q;
    logic             comp_q;

    trigger_match #(
        .SAMPLE_W(SAMPLE_W)
    ) u_match (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .clear        (state == DISARMED),
        .cfg_mask     (cfg_mask),
        .cfg_value    (cfg_value),
        .cfg_edge_mask(cfg_edge_mask),
        .cfg_edge_pol (cfg_edge_pol),
        .qualify      (qualify)
    );

    assign fsm_quiet    = !idle && !pre_trigger && !post_trigger;
    assign match_target = (cfg_match_count == '0) ? CNT_W'(1) : cfg_match_count;
    assign match_inc    = {1'b0, match_cnt} + 1'b1;
    assign post_inc     = {1'b0, post_cnt} + 1'b1;

    // post_trigger takes priority over pre_trigger, idle over everything
    assign armed_active = (state == ARMED) && !idle && pre_trigger && !post_trigger;
    assign post_active  = (state == POST) && !idle && !fsm_quiet;

    assign fire   = armed_active && qualify && (match_inc == {1'b0, match_target});
    assign finish = post_active &&
                    ((cfg_post_samples == '0) ||
                     (sample_valid && (post_inc == {1'b0, cfg_post_samples})));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DISARMED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (idle || fsm_quiet) begin
            state_next = DISARMED;
        end else begin
            case (state)
                DISARMED: if (pre_trigger && !post_trigger) state_next = ARMED;
                ARMED:    if (fire)                         state_next = FIRED;
                FIRED:    if (post_trigger)                 state_next = POST;
                POST:     if (finish)                       state_next = DONE;
                DONE:     state_next = DONE;
                default:  state_next = DISARMED;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            match_cnt <= '0;
            post_cnt  <= '0;
            pre_cnt   <= '0;
            saw_q     <= 1'b0;
            comp_q    <= 1'b0;
        end else begin
            saw_q  <= fire;
            comp_q <= finish;

            if (!armed_active) begin
                match_cnt <= '0;
            end else if (sample_valid) begin
                match_cnt <= qualify ? match_inc[CNT_W-1:0] : '0;
            end

            // Frozen outside ARMED so the FSM can read it after the trigger
            if (idle || (state == DISARMED)) begin
                pre_cnt <= '0;
            end else if (armed_active && sample_valid && (pre_cnt != {CNT_W{1'b1}})) begin
                pre_cnt <= pre_cnt + 1'b1;
            end

            if (!post_active) begin
                post_cnt <= '0;
            end else if (sample_valid) begin
                post_cnt <= post_inc[CNT_W-1:0];
            end
        end
    end

    assign saw_trigger = saw_q;
    assign complete    = comp_q;
    assign pre_count   = pre_cnt;

endmodule

// File: tb/tb_capture_trigger_unit.sv
// Vector-table bench for capture_trigger_unit with a per-cycle expectation scoreboard.
module tb_capture_trigger_unit;
    import capture_pkg::*;

    localparam int SW = 16;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sample_valid = 1'b0;
    logic [SW-1:0] sample = '0;
    logic          idle = 1'b0;
    logic          pre_trigger = 1'b0;
    logic          post_trigger = 1'b0;
    logic [SW-1:0] cfg_mask = '0;
    logic [SW-1:0] cfg_value = '0;
    logic [SW-1:0] cfg_edge_mask = '0;
    logic [SW-1:0] cfg_edge_pol = '0;
    logic [CW-1:0] cfg_match_count = '0;
    logic [CW-1:0] cfg_post_samples = '0;
    logic          saw_trigger;
    logic          complete;
    logic [CW-1:0] pre_count;

    always #5 clock = ~clock;

    capture_trigger_unit #(.SAMPLE_W(SW), .CNT_W(CW)) dut (
        .clock           (clock),
        .reset           (reset),
        .sample_valid    (sample_valid),
        .sample          (sample),
        .idle            (idle),
        .pre_trigger     (pre_trigger),
        .post_trigger    (post_trigger),
        .cfg_mask        (cfg_mask),
        .cfg_value       (cfg_value),
        .cfg_edge_mask   (cfg_edge_mask),
        .cfg_edge_pol    (cfg_edge_pol),
        .cfg_match_count (cfg_match_count),
        .cfg_post_samples(cfg_post_samples),
        .saw_trigger     (saw_trigger),
        .complete        (complete),
        .pre_count       (pre_count)
    );

    typedef struct {
        string         tag;
        logic          rst;
        logic          idl;
        logic          pre;
        logic          pst;
        logic          vld;
        logic [SW-1:0] smp;
        logic          e_trig;
        logic          e_comp;
        int            e_pre;   // -1: pre_count not checked
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input string tag, input logic rst, input logic idl, input logic pre,
                       input logic pst, input logic vld, input logic [SW-1:0] smp,
                       input logic et, input logic ec, input int ep);
        vec_t v;
        v.tag = tag; v.rst = rst; v.idl = idl; v.pre = pre; v.pst = pst;
        v.vld = vld; v.smp = smp; v.e_trig = et; v.e_comp = ec; v.e_pre = ep;
        tbl.push_back(v);
    endtask

    task automatic cfg(input logic [SW-1:0] m, input logic [SW-1:0] v, input logic [SW-1:0] em,
                       input logic [SW-1:0] ep, input logic [CW-1:0] mc, input logic [CW-1:0] ps);
        cfg_mask = m; cfg_value = v; cfg_edge_mask = em; cfg_edge_pol = ep;
        cfg_match_count = mc; cfg_post_samples = ps;
    endtask

    // Drive each row at a falling edge, compare after the following rising edge
    task automatic run_table();
        vec_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            reset        = tbl[i].rst;
            idle         = tbl[i].idl;
            pre_trigger  = tbl[i].pre;
            post_trigger = tbl[i].pst;
            sample_valid = tbl[i].vld;
            sample       = tbl[i].smp;
            sb.push_back(tbl[i]);
            @(negedge clock);
            e = sb.pop_front();
            chk({e.tag, " saw_trigger"}, 32'(saw_trigger), 32'(e.e_trig));
            chk({e.tag, " complete"}, 32'(complete), 32'(e.e_comp));
            if (e.e_pre >= 0) chk({e.tag, " pre_count"}, 32'(pre_count), e.e_pre);
        end
        tbl.delete();
    endtask

    initial begin
        @(negedge clock);

        // Reset state, then basic level trigger with post count of 4
        cfg(16'h00FF, 16'h0012, 16'h0000, 16'h0000, 1, 4);
        add("reset",   1, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
        add("l.idle",  0, 1, 0, 0, 0, 16'h0000, 0, 0, 0);
        add("l.arm",   0, 0, 1, 0, 0, 16'h0000, 0, 0, 0);
        add("l.miss",  0, 0, 1, 0, 1, 16'h0011, 0, 0, 1);
        add("l.hit",   0, 0, 1, 0, 1, 16'hAB12, 1, 0, 2);
        add("l.fired", 0, 0, 1, 0, 1, 16'h0012, 0, 0, 2);
        add("l.post",  0, 0, 0, 1, 0, 16'h0000, 0, 0, 2);
        add("l.p1",    0, 0, 0, 1, 1, 16'h1234, 0, 0, 2);
        add("l.pgap",  0, 0, 0, 1, 0, 16'h0000, 0, 0, 2);
        add("l.p2",    0, 0, 0, 1, 1, 16'h1234, 0, 0, 2);
        add("l.p3",    0, 0, 0, 1, 1, 16'h1234, 0, 0, 2);
        add("l.p4",    0, 0, 0, 1, 1, 16'h1234, 0, 1, 2);
        add("l.done",  0, 0, 0, 1, 0, 16'h0000, 0, 0, 2);
        add("l.back",  0, 1, 0, 0, 0, 16'h0000, 0, 0, 0);
        run_table();

        // Three consecutive matches required; miss clears, invalid cycle does not
        cfg(16'h00FF, 16'h0012, 16'h0000, 16'h0000, 3, 1);
        add("m.arm",   0, 0, 1, 0, 0, 16'h0000, 0, 0, 0);
        add("m.s1",    0, 0, 1, 0, 1, 16'h5512, 0, 0, 1);
        add("m.s2",    0, 0, 1, 0, 1, 16'h0012, 0, 0, 2);
        add("m.miss",  0, 0, 1, 0, 1, 16'h0000, 0, 0, 3);
        add("m.s4",    0, 0, 1, 0, 1, 16'h0012, 0, 0, 4);
        add("m.gap",   0, 0, 1, 0, 0, 16'h0000, 0, 0, 4);
        add("m.s5",    0, 0, 1, 0, 1, 16'hFF12, 0, 0, 5);
        add("m.s6",    0, 0, 1, 0, 1, 16'h0012, 1, 0, 6);
        add("m.hold",  0, 0, 1, 0, 1, 16'h0012, 0, 0, 6);
        add("m.post",  0, 0, 0, 1, 0, 16'h0000, 0, 0, 6);
        add("m.p1",    0, 0, 0, 1, 1, 16'h0000, 0, 1, 6);
        add("m.done",  0, 0, 0, 1, 0, 16'h0000, 0, 0, 6);
        add("m.idle",  0, 1, 0, 0, 0, 16'h0000, 0, 0, 0);
        run_table();

        // Zero post samples: complete without any valid post sample
        cfg(16'h00FF, 16'h0012, 16'h0000, 16'h0000, 0, 0);
        add("z.arm",   0, 0, 1, 0, 0, 16'h0000, 0, 0, 0);
        add("z.hit",   0, 0, 1, 0, 1, 16'h0012, 1, 0, 1);
        add("z.hold",  0, 0, 1, 0, 0, 16'h0000, 0, 0, 1);
        add("z.post",  0, 0, 0, 1, 0, 16'h0000, 0, 0, 1);
        add("z.first", 0, 0, 0, 1, 0, 16'h0000, 0, 1, 1);
        add("z.done",  0, 0, 0, 1, 0, 16'h0000, 0, 0, 1);
        add("z.idle",  0, 1, 0, 0, 0, 16'h0000, 0, 0, 0);
        run_table();

        // Abort at 2 of 3, idle colliding with a trigger, then a full re-arm
        cfg(16'h00FF, 16'h0012, 16'h0000, 16'h0000, 3, 1);
        add("a.arm",   0, 0, 1, 0, 0, 16'h0000, 0, 0, 0);
        add("a.s1",    0, 0, 1, 0, 1, 16'h0012, 0, 0, 1);
        add("a.s2",    0, 0, 1, 0, 1, 16'h0012, 0, 0, 2);
        add("a.abort", 0, 1, 0, 0, 0, 16'h0000, 0, 0, 0);
        add("a.rearm", 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0);
        add("a.r1",    0, 0, 1, 0, 1, 16'h0012, 0, 0, 1);
        add("a.r2",    0, 0, 1, 0, 1, 16'h0012, 0, 0, 2);
        add("a.idlhit",0, 1, 1, 0, 1, 16'h0012, 0, 0, 0);
        add("a.arm2",  0, 0, 1, 0, 0, 16'h0000, 0, 0, 0);
        add("a.q1",    0, 0, 1, 0, 1, 16'h0012, 0, 0, 1);
        add("a.q2",    0, 0, 1, 0, 1, 16'h0012, 0, 0, 2);
        add("a.q3",    0, 0, 1, 0, 1, 16'h0012, 1, 0, 3);
        add("a.idle",  0, 1, 0, 0, 0, 16'h0000, 0, 0, 0);
        run_table();

`ifdef CAPTURE_TRIGGER_EDGE_EN
        // Rising edge on bit 0; first sample after arming has no predecessor
        cfg(16'h0000, 16'h0000, 16'h0001, 16'h0001, 1, 1);
        add("e.arm",   0, 0, 1, 0, 0, 16'h0000, 0, 0, 0);
        add("e.first", 0, 0, 1, 0, 1, 16'h0001, 0, 0, 1);
        add("e.fall",  0, 0, 1, 0, 1, 16'h0000, 0, 0, 2);
        add("e.rise",  0, 0, 1, 0, 1, 16'h0001, 1, 0, 3);
        add("e.hold",  0, 0, 1, 0, 0, 16'h0000, 0, 0, 3);
        add("e.idle",  0, 1, 0, 0, 0, 16'h0000, 0, 0, 0);
        add("e.arm2",  0, 0, 1, 0, 0, 16'h0000, 0, 0, 0);
        add("e.f2",    0, 0, 1, 0, 1, 16'h0001, 0, 0, 1);
        add("e.fall2", 0, 0, 1, 0, 1, 16'h0000, 0, 0, 2);
        add("e.idle2", 0, 1, 0, 0, 0, 16'h0000, 0, 0, 0);
        run_table();
`else
        // Edge config is ignored: an all-zero level mask matches the first sample
        cfg(16'h0000, 16'h0000, 16'h0001, 16'h0001, 1, 1);
        add("e.arm",   0, 0, 1, 0, 0, 16'h0000, 0, 0, 0);
        add("e.first", 0, 0, 1, 0, 1, 16'h0001, 1, 0, 1);
        add("e.hold",  0, 0, 1, 0, 0, 16'h0000, 0, 0, 1);
        add("e.idle",  0, 1, 0, 0, 0, 16'h0000, 0, 0, 0);
        run_table();
`endif

        // Reset in the middle of POST: everything clears and complete never fires
        cfg(16'h00FF, 16'h0012, 16'h0000, 16'h0000, 1, 4);
        add("r.arm",   0, 0, 1, 0, 0, 16'h0000, 0, 0, 0);
        add("r.hit",   0, 0, 1, 0, 1, 16'h0012, 1, 0, 1);
        add("r.post",  0, 0, 0, 1, 0, 16'h0000, 0, 0, 1);
        add("r.p1",    0, 0, 0, 1, 1, 16'h0000, 0, 0, 1);
        add("r.p2",    0, 0, 0, 1, 1, 16'h0000, 0, 0, 1);
        run_table();
        reset        = 1'b1;
        post_trigger = 1'b1;
        sample_valid = 1'b1;
        @(negedge clock);
        chk("rpost saw_trigger", 32'(saw_trigger), 32'd0);
        chk("rpost complete", 32'(complete), 32'd0);
        chk("rpost pre_count", 32'(pre_count), 32'd0);
        chk("rpost state", 32'(dut.state), 32'(DISARMED));
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("rpost no complete", 32'(complete), 32'd0);
            chk("rpost no trigger", 32'(saw_trigger), 32'd0);
        end
        post_trigger = 1'b0;
        sample_valid = 1'b0;
        idle         = 1'b1;
        @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/capture_trigger_unit.md
# capture_trigger_unit

Trigger qualifier and post-trigger sample counter for the logic capture peripheral. It sits directly upstream of the analyzer control FSM. It watches the incoming sample stream while the FSM reports pre-trigger, and raises `saw_trigger` when the programmed level/edge/occurrence condition is met. It then counts post-trigger samples and raises `complete` when the programmed count is reached, which returns the FSM to idle.

## Interface
Parameters:
- `SAMPLE_W`, default 16: sample width in bits.
- `CNT_W`, default 16: width of all sample counters.

Ports:
- `clock`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `sample_valid`, in, 1: `sample` is valid this cycle.
- `sample`, in, SAMPLE_W: captured probe inputs.
- `idle`, in, 1: FSM idle state.
- `pre_trigger`, in, 1: FSM sampling, pre-trigger.
- `post_trigger`, in, 1: FSM sampling, post-trigger.
- `cfg_mask`, in, SAMPLE_W: 1 = bit takes part in the level compare.
- `cfg_value`, in, SAMPLE_W: level compare value.
- `cfg_edge_mask`, in, SAMPLE_W: 1 = bit must show an edge (only when edge support is compiled in).
- `cfg_edge_pol`, in, SAMPLE_W: 1 = rising, 0 = falling, per bit.
- `cfg_match_count`, in, CNT_W: number of consecutive qualifying samples required; 0 is treated as 1.
- `cfg_post_samples`, in, CNT_W: number of samples to take after the trigger.
- `saw_trigger`, out, 1: one-cycle pulse to the FSM.
- `complete`, out, 1: one-cycle pulse to the FSM.
- `pre_count`, out, CNT_W: valid samples seen in pre-trigger, saturating; frozen at the trigger.

## Operation
- Internal states:
  - `DISARMED` is entered from reset, or whenever `idle`=1 or all FSM inputs are 0.
  - `DISARMED`→`ARMED` when `pre_trigger`=1.
  - `ARMED`→`FIRED` on a qualifying trigger.
  - `FIRED`→`POST` when `post_trigger`=1.
  - `POST`→`DONE` when the post count is reached.
  - `DONE`→`DISARMED` when `idle`=1.
  - Any state→`DISARMED` when `idle`=1; this covers an FSM abort.
- Level match: `((sample ^ cfg_value) & cfg_mask) == 0`. A mask of all zeros matches every sample.
- Edge match (macro enabled):
  - Every bit set in `cfg_edge_mask` must show `prev`≠`sample` in the `cfg_edge_pol` direction. An edge mask of all zeros is always true.
  - `prev` is the last valid sample, held in a register with a `prev_ok` flag. `prev_ok` is cleared in `DISARMED`, so the first sample after arming can never produce an edge.
- Qualifying sample: `sample_valid` & level match & edge match.
- Consecutive match counter:
  - +1 on each qualifying sample.
  - Cleared on any valid sample that does not qualify.
  - Not changed on cycles with `sample_valid`=0.
  - The trigger fires when the count reaches max(`cfg_match_count`, 1).
- `pre_count` increments on every valid sample in `ARMED`, including the trigger sample. It saturates at 2^CNT_W−1 and is cleared on entry to `ARMED`.
- Post counter:
  - Cleared in `FIRED`.
  - +1 per valid sample in `POST`.
  - `complete` pulses when the count equals `cfg_post_samples`.
  - If `cfg_post_samples`=0, `complete` pulses on the first `POST` cycle.
- The `cfg_*` inputs are static while not `DISARMED`; behaviour is undefined if they change.
- If `pre_trigger` and `post_trigger` are both high, `post_trigger` wins.
- If `idle` and a trigger occur in the same cycle, `idle` wins: no pulse is issued and all counters are cleared.

## Timing
- Reset values: `saw_trigger`=0, `complete`=0, `pre_count`=0. State is `DISARMED` and all internal counters and `prev_ok` are 0.
- `saw_trigger` is registered: it is high exactly one cycle, in cycle N+1 after the qualifying sample accepted in cycle N.
- `complete` is registered: it is high exactly one cycle, the cycle after the final post sample is accepted.
- No further `saw_trigger` is issued until the block passes through `DISARMED` again.
- `pre_count` is valid from the cycle `saw_trigger` is high and holds until `DISARMED`.

## Configuration
- `CAPTURE_TRIGGER_EDGE_EN` defined:
  - Edge matching, the `prev` register and `prev_ok` are built.
- Not defined:
  - The edge match is constant true and no `prev` register is built.
  - `cfg_edge_mask` and `cfg_edge_pol` stay on the port list but are ignored.

## Structure
- Shared package `capture_pkg` holds:
  - the state enum `trig_state_t` (`DISARMED`, `ARMED`, `FIRED`, `POST`, `DONE`);
  - default widths `CAPTURE_SAMPLE_W`=16 and `CAPTURE_CNT_W`=16.
- One sub-module, `trigger_match`: combinational level/edge compare plus the `prev` register. It takes `clock`, `reset`, `sample_valid`, `sample`, `clear` and the config inputs, and outputs `qualify`.
- Counters and the state machine live in the top level.

## Test plan
- Level match, mask=0x00FF, value=0x0012, match_count=1, post=4. Samples 0x0011, then 0xAB12 in cycle N. Required: `saw_trigger` high in N+1 only; `pre_count`=2; `complete` one cycle after the 4th post sample.
- Match count=3 with samples match, match, miss, match, match, match. Required: trigger on the 6th sample; an invalid cycle between matches does not reset the count.
- Edge (macro on), edge_mask=0x0001, pol=1, level mask=0. The first sample after arm is 0x0001 (no `prev`), so no trigger. Stream 0x0000 then 0x0001 → trigger. 0x0001 then 0x0000 → no trigger.
- `cfg_post_samples`=0: `complete` pulses on the first `POST` cycle with no valid samples required.
- Abort: `idle` asserted mid-`ARMED` with match count 2 of 3. Required: no `saw_trigger`, counters cleared. On re-arm, a full 3 matches is needed.
- Reset asserted during `POST`: next cycle all outputs are 0 and the state is `DISARMED`; `complete` never pulses.
